// File: rtl/grf_wb_arbiter.sv
// Write-side front end of the GRF: merges pipeline writes (A) and queued
// multi-cycle producer writes (B) onto the single register-file write port.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_reg,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_reg,
  input  logic [31:0]              b_data,
  output logic                     a_stall,
  output logic                     wr_en,
  output logic [4:0]               wr_reg,
  output logic [31:0]              wr_data,
  output logic [$clog2(DEPTH):0]   q_count,
  input  logic [4:0]               pend_reg1,
  input  logic [4:0]               pend_reg2,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [7:0]    age;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          take_a;
  logic          hit1;
  logic          hit2;
  logic [AW-1:0] idx;

  // Pointer MSB differs when the buffer has wrapped: equal low bits then means full.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);

  // Write-port selection: a starved head beats the pipeline, then A, then the FIFO.
  always_comb begin
    b_ready = !full;
    a_stall = !empty && (age >= 8'(STARVE_LIMIT));
    push    = b_valid && !full && (b_reg != 5'd0);
    pop     = 1'b0;
    take_a  = 1'b0;
    if (a_stall) begin
      pop = 1'b1;
    end else if (a_valid && (a_reg != 5'd0)) begin
      take_a = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
    end
  end

  // Outstanding-write lookup over the occupied FIFO slots plus the staged write.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr[AW-1:0] + AW'(k);
      if (PW'(k) < q_count) begin
        if (fifo_reg[idx] == pend_reg1) hit1 = 1'b1;
        if (fifo_reg[idx] == pend_reg2) hit2 = 1'b1;
      end
    end
    pend1 = (pend_reg1 != 5'd0) && (hit1 || (wr_en && (wr_reg == pend_reg1)));
    pend2 = (pend_reg2 != 5'd0) && (hit2 || (wr_en && (wr_reg == pend_reg2)));
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr[AW-1:0]]  <= b_reg;
      fifo_data[wr_ptr[AW-1:0]] <= b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
      age     <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   q_count <= q_count + PW'(1);
        2'b01:   q_count <= q_count - PW'(1);
        default: q_count <= q_count;
      endcase

      if (empty || pop) begin
        age <= '0;
      end else if (age != 8'hFF) begin
        age <= age + 8'd1;
      end

      if (pop) begin
        wr_en   <= 1'b1;
        wr_reg  <= fifo_reg[rd_ptr[AW-1:0]];
        wr_data <= fifo_data[rd_ptr[AW-1:0]];
      end else if (take_a) begin
        wr_en   <= 1'b1;
        wr_reg  <= a_reg;
        wr_data <= a_data;
      end else begin
        wr_en   <= 1'b0;
      end

      if (a_valid && a_stall) err <= 1'b1;
    end
  end

endmodule
